// File: rtl/ibuf_pkg.sv
// Shared types and default widths for the fetch-to-decode instruction buffer.
package ibuf_pkg;

  localparam int IBUF_SIZE   = 32;
  localparam int IBUF_DEPTH  = 16;
  localparam int FETCH_W_DEF = 5;
  localparam int ISSUE_W_DEF = 3;

  typedef struct packed {
    logic [IBUF_SIZE-1:0] instruction;
    logic [IBUF_SIZE-1:0] pc;
    logic [IBUF_SIZE-1:0] imm;
    logic [IBUF_SIZE-1:0] pred_pc;
    logic                 branch_pred;
  } ibuf_entry_t;

endpackage

// File: rtl/lead_ones_count.sv
// Counts consecutive ones starting at bit 0; everything above the first zero is ignored.
module lead_ones_count #(
  parameter int W = 5
) (
  input  logic [W-1:0]               bits,
  output logic [$clog2(W+1)-1:0]     n
);

  // Scan upward from bit 0 until the first zero is seen.
  always_comb begin
    logic run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (run && bits[i]) begin
        n = n + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_buffer_super.sv
// Multi-lane circular FIFO decoupling 5-wide fetch from 3-wide decode.
module instruction_buffer_super
  import ibuf_pkg::*;
#(
  parameter int size    = IBUF_SIZE,
  parameter int DEPTH   = IBUF_DEPTH,
  parameter int FETCH_W = FETCH_W_DEF,
  parameter int ISSUE_W = ISSUE_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [FETCH_W-1:0]        fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [FETCH_W*size-1:0]   instruction_i,
  input  logic [FETCH_W*size-1:0]   pc_i,
  input  logic [FETCH_W*size-1:0]   imm_i,
  input  logic [FETCH_W*size-1:0]   pred_pc_i,
  input  logic [FETCH_W-1:0]        branch_pred_i,
  output logic [ISSUE_W-1:0]        dispatch_valid_o,
  input  logic [ISSUE_W-1:0]        dispatch_ready_i,
  output logic [ISSUE_W*size-1:0]   instruction_o,
  output logic [ISSUE_W*size-1:0]   pc_o,
  output logic [ISSUE_W*size-1:0]   imm_o,
  output logic [ISSUE_W*size-1:0]   pred_pc_o,
  output logic [ISSUE_W-1:0]        branch_pred_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PNW = $clog2(FETCH_W + 1);
  localparam int QNW = $clog2(ISSUE_W + 1);

  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  free_slots;
  logic [PNW-1:0] n_push_raw;
  logic [PNW-1:0] n_push;
  logic [QNW-1:0] n_pop;
  logic [ISSUE_W-1:0] pop_req;

  ibuf_entry_t mem [DEPTH];

  lead_ones_count #(.W(FETCH_W)) u_push_cnt (
    .bits (fetch_valid_i),
    .n    (n_push_raw)
  );

  lead_ones_count #(.W(ISSUE_W)) u_pop_cnt (
    .bits (pop_req),
    .n    (n_pop)
  );

  // Ready reflects registered occupancy only, so pops in this cycle never enable a push.
  assign free_slots    = CW'(DEPTH) - count;
  assign fetch_ready_o = (free_slots >= CW'(FETCH_W));
  assign n_push        = fetch_ready_o ? n_push_raw : '0;
  assign pop_req       = dispatch_valid_o & dispatch_ready_i;
  assign count_o       = count;

  // Pointer and occupancy state; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + PW'(n_pop);
      tail_ptr <= tail_ptr + PW'(n_push);
      count    <= count + CW'(n_push) - CW'(n_pop);
    end
  end

  // Entry storage is deliberately left unreset; lanes wrap naturally via pointer width.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (!flush && (PNW'(k) < n_push)) begin
        mem[tail_ptr + PW'(k)] <= '{
          instruction: instruction_i[k*size +: size],
          pc:          pc_i[k*size +: size],
          imm:         imm_i[k*size +: size],
          pred_pc:     pred_pc_i[k*size +: size],
          branch_pred: branch_pred_i[k]
        };
      end
    end
  end

  // Head window presented oldest-first; invalid lanes drive zero.
  always_comb begin
    ibuf_entry_t e;
    dispatch_valid_o = '0;
    instruction_o    = '0;
    pc_o             = '0;
    imm_o            = '0;
    pred_pc_o        = '0;
    branch_pred_o    = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      e = mem[head_ptr + PW'(j)];
      if (count > CW'(j)) begin
        dispatch_valid_o[j]          = 1'b1;
        instruction_o[j*size +: size] = e.instruction;
        pc_o[j*size +: size]          = e.pc;
        imm_o[j*size +: size]         = e.imm;
        pred_pc_o[j*size +: size]     = e.pred_pc;
        branch_pred_o[j]              = e.branch_pred;
      end else begin
        dispatch_valid_o[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_buffer_super.sv
// Directed self-checking bench for instruction_buffer_super.
module tb_instruction_buffer_super;

  localparam int SZ = 32;
  localparam int FW = 5;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [FW-1:0]   fetch_valid_i = '0;
  logic            fetch_ready_o;
  logic [FW*SZ-1:0] instruction_i = '0;
  logic [FW*SZ-1:0] pc_i = '0;
  logic [FW*SZ-1:0] imm_i = '0;
  logic [FW*SZ-1:0] pred_pc_i = '0;
  logic [FW-1:0]   branch_pred_i = '0;
  logic [IW-1:0]   dispatch_valid_o;
  logic [IW-1:0]   dispatch_ready_i = '0;
  logic [IW*SZ-1:0] instruction_o;
  logic [IW*SZ-1:0] pc_o;
  logic [IW*SZ-1:0] imm_o;
  logic [IW*SZ-1:0] pred_pc_o;
  logic [IW-1:0]   branch_pred_o;
  logic [4:0]      count_o;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_buffer_super dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .instruction_i    (instruction_i),
    .pc_i             (pc_i),
    .imm_i            (imm_i),
    .pred_pc_i        (pred_pc_i),
    .branch_pred_i    (branch_pred_i),
    .dispatch_valid_o (dispatch_valid_o),
    .dispatch_ready_i (dispatch_ready_i),
    .instruction_o    (instruction_o),
    .pc_o             (pc_o),
    .imm_o            (imm_o),
    .pred_pc_o        (pred_pc_o),
    .branch_pred_o    (branch_pred_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus: lane k carries pc = base + 4k, instr = 0x13 | (k<<8) | base<<4.
  task automatic step(input logic [FW-1:0] fv, input logic [31:0] base,
                      input logic [IW-1:0] rdy, input logic fl);
    fetch_valid_i    = fv;
    dispatch_ready_i = rdy;
    flush            = fl;
    for (int k = 0; k < FW; k++) begin
      pc_i[k*SZ +: SZ]          = base + 32'(4 * k);
      instruction_i[k*SZ +: SZ] = 32'h0000_0013 | (32'(k) << 8) | (base << 4);
      imm_i[k*SZ +: SZ]         = (base + 32'(4 * k)) ^ 32'hA5A5_0000;
      pred_pc_i[k*SZ +: SZ]     = base + 32'(4 * k) + 32'h0000_1000;
      branch_pred_i[k]          = k[0];
    end
    @(posedge clk);
    #1;
    fetch_valid_i    = '0;
    dispatch_ready_i = '0;
    flush            = 1'b0;
  endtask

  initial begin
    // Reset held: outputs quiet.
    @(posedge clk);
    #1;
    check("rst_valid", 64'(dispatch_valid_o), 64'h0);
    check("rst_count", 64'(count_o), 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 64'(fetch_ready_o), 64'h1);
    check("rel_valid", 64'(dispatch_valid_o), 64'h0);
    check("rel_count", 64'(count_o), 64'h0);

    // First group of 5, entries 0..4.
    step(5'b11111, 32'h0, 3'b000, 1'b0);
    check("p1_count", 64'(count_o), 64'd5);
    check("p1_valid", 64'(dispatch_valid_o), 64'h7);
    check("p1_pc0", 64'(pc_o[0 +: SZ]), 64'h0);
    check("p1_pc1", 64'(pc_o[SZ +: SZ]), 64'h4);
    check("p1_pc2", 64'(pc_o[2*SZ +: SZ]), 64'h8);
    check("p1_ins0", 64'(instruction_o[0 +: SZ]), 64'h13);
    check("p1_ins1", 64'(instruction_o[SZ +: SZ]), 64'h113);
    check("p1_imm2", 64'(imm_o[2*SZ +: SZ]), 64'hA5A5_0008);
    check("p1_ppc1", 64'(pred_pc_o[SZ +: SZ]), 64'h1004);
    check("p1_bp", 64'(branch_pred_o), 64'b010);

    // Fill to 12: entries 5..9 (pc 0x14..), then 10..11 (pc 0x28..).
    step(5'b11111, 32'h14, 3'b000, 1'b0);
    step(5'b00011, 32'h28, 3'b000, 1'b0);
    check("f_count12", 64'(count_o), 64'd12);
    check("f_ready0", 64'(fetch_ready_o), 64'h0);
    step(5'b11111, 32'h800, 3'b000, 1'b0);
    check("f_drop_cnt", 64'(count_o), 64'd12);
    step(5'b00000, 32'h0, 3'b111, 1'b0);
    check("f_pop_cnt", 64'(count_o), 64'd9);
    check("f_ready1", 64'(fetch_ready_o), 64'h1);
    check("f_pc0", 64'(pc_o[0 +: SZ]), 64'hC);
    check("f_pc2", 64'(pc_o[2*SZ +: SZ]), 64'h14);

    // Non-prefix valids push 3; ready=101 pops only lane 0.
    step(5'b10111, 32'h40, 3'b000, 1'b0);
    check("np_push", 64'(count_o), 64'd12);
    step(5'b00000, 32'h0, 3'b101, 1'b0);
    check("np_pop", 64'(count_o), 64'd11);
    check("np_head", 64'(pc_o[0 +: SZ]), 64'h10);

    // Steer head and tail to 14 with the buffer empty.
    step(5'b00000, 32'h0, 3'b000, 1'b1);
    step(5'b11111, 32'h0, 3'b000, 1'b0);
    step(5'b11111, 32'h0, 3'b111, 1'b0);
    step(5'b01111, 32'h0, 3'b111, 1'b0);
    check("w_cnt8", 64'(count_o), 64'd8);
    step(5'b00000, 32'h0, 3'b111, 1'b0);
    step(5'b00000, 32'h0, 3'b111, 1'b0);
    step(5'b00000, 32'h0, 3'b011, 1'b0);
    check("w_empty", 64'(count_o), 64'd0);
    check("w_valid0", 64'(dispatch_valid_o), 64'h0);
    step(5'b11111, 32'h100, 3'b000, 1'b0);
    check("w_count", 64'(count_o), 64'd5);
    check("w_pc0", 64'(pc_o[0 +: SZ]), 64'h100);
    check("w_pc1", 64'(pc_o[SZ +: SZ]), 64'h104);
    check("w_pc2", 64'(pc_o[2*SZ +: SZ]), 64'h108);
    step(5'b00000, 32'h0, 3'b111, 1'b0);
    check("w2_valid", 64'(dispatch_valid_o), 64'b011);
    check("w2_pc0", 64'(pc_o[0 +: SZ]), 64'h10C);
    check("w2_pc1", 64'(pc_o[SZ +: SZ]), 64'h110);
    check("w2_pc2z", 64'(pc_o[2*SZ +: SZ]), 64'h0);

    // Flush beats a simultaneous push and pop.
    step(5'b11111, 32'h300, 3'b111, 1'b1);
    check("fl_count", 64'(count_o), 64'd0);
    check("fl_valid", 64'(dispatch_valid_o), 64'h0);
    check("fl_ready", 64'(fetch_ready_o), 64'h1);
    step(5'b11111, 32'h200, 3'b000, 1'b0);
    check("fl_push_cnt", 64'(count_o), 64'd5);
    check("fl_push_pc0", 64'(pc_o[0 +: SZ]), 64'h200);

    // Mid-operation reset clears everything at once.
    #2;
    reset = 1'b0;
    #1;
    check("ar_count", 64'(count_o), 64'd0);
    check("ar_valid", 64'(dispatch_valid_o), 64'h0);
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_buffer_super.md
Name: instruction_buffer_super

Overview:
Decoupling FIFO between the 5-wide multi-fetch stage and the 3-wide decode/dispatch stage of the superscalar core. Each cycle it accepts up to FETCH_W instructions with their metadata (PC, immediate, prediction PC, prediction bit) and presents up to ISSUE_W oldest entries in program order to decode. Its fetch_ready_o drives the fetch stage's ready input, which throttles PC advance. Flush empties it on misprediction.

Parameters:
size, 32, data/PC width
DEPTH, 16, entry count; power of 2, at least FETCH_W+ISSUE_W
FETCH_W, 5, write lanes
ISSUE_W, 3, read lanes

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
flush  in  1  discard all entries (misprediction)
fetch_valid_i  in  FETCH_W  per-lane write valid, prefix-shaped
fetch_ready_o  out  1  buffer can take a full FETCH_W group this cycle
instruction_i  in  FETCH_W*size  instructions, lane 0 in LSBs
pc_i  in  FETCH_W*size  PC per lane
imm_i  in  FETCH_W*size  early-decoded immediate per lane
pred_pc_i  in  FETCH_W*size  pc_value_at_prediction per lane
branch_pred_i  in  FETCH_W  predicted-taken bit per lane
dispatch_valid_o  out  ISSUE_W  per-lane read valid, prefix-shaped
dispatch_ready_i  in  ISSUE_W  per-lane decode accept, prefix-shaped
instruction_o, pc_o, imm_o, pred_pc_o  out  ISSUE_W*size each  head entries, oldest in lane 0
branch_pred_o  out  ISSUE_W  prediction bit per read lane
count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State: head_ptr and tail_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. count register 0..DEPTH. Storage array of DEPTH entries; storage is not reset.
- Reset (reset=0, asynchronous): head_ptr=0, tail_ptr=0, count=0.
  - Outputs during and after reset: dispatch_valid_o=0, count_o=0, fetch_ready_o=1 once released.
- Push count n_push = number of leading ones of fetch_valid_i. Bits after the first zero are ignored.
  - Writes occur only if fetch_ready_o=1. Lane k goes to entry (tail_ptr+k) mod DEPTH.
  - tail_ptr advances by n_push.
- fetch_ready_o = (DEPTH - count) >= FETCH_W. It is combinational from registered count only and does not credit same-cycle pops.
  - If fetch_valid_i!=0 while fetch_ready_o=0, the data is dropped with no state change.
- Read side:
  - dispatch_valid_o[j] = (count > j).
  - Lane j data = entry (head_ptr+j) mod DEPTH.
  - Data outputs are forced to 0 on lanes whose valid is 0.
- Pop count n_pop = leading ones of (dispatch_valid_o & dispatch_ready_i). head_ptr advances by n_pop.
- Next count = count + n_push - n_pop. Simultaneous push and pop are legal and never overflow or underflow, because push requires free >= FETCH_W.
- Latency: an entry written in cycle N appears on dispatch outputs in cycle N+1. There is no bypass when empty.
- Flush (synchronous, highest priority): next head_ptr=0, tail_ptr=0, count=0.
  - Same-cycle pushes and pops are discarded.
  - The cycle after flush: dispatch_valid_o=0 and fetch_ready_o=1.
- Ordering: program order is preserved across wrap-around. Lanes that wrap past DEPTH-1 continue at index 0.
- Reset asserted mid-operation aborts everything immediately. Contents are considered lost.
- count_o = count (registered).

Decomposition:
- Package ibuf_pkg:
  - ibuf_entry_t struct holding instruction, pc, imm, pred_pc, branch_pred.
  - Default constants FETCH_W=5, ISSUE_W=3.
- One sub-module lead_ones_count (parameterised width, returns the number of leading ones from bit 0). Instantiated for both push and pop.

Test Plan:
- Reset, then release: dispatch_valid_o=000, fetch_ready_o=1, count_o=0. Outputs are 0 throughout reset.
- Push 5 instructions 0x00000013.. with PCs 0x0,0x4,..,0x10, dispatch_ready_i=000. Next cycle: count_o=5, dispatch_valid_o=111, pc_o lanes = 0x0,0x4,0x8.
- Fill to 12 with ready held low: fetch_ready_o=0 (free=4). A fetch_valid_i=11111 push that cycle is dropped and count stays 12. Then ready=111 for one cycle: count 9, fetch_ready_o=1.
- Non-prefix fetch_valid_i=10111 pushes exactly 3. Pop with dispatch_ready_i=101 pops exactly 1 (lane 0) and head advances by 1.
- Wrap-around: head=tail=14 with count 0, push 5 with PCs 0x100..0x110. Entries land at 14,15,0,1,2 and dispatch order is 0x100,0x104,0x108.
- Flush asserted with a push of 5 and ready=111 in the same cycle. Next cycle: count_o=0, dispatch_valid_o=000, fetch_ready_o=1, and a subsequent push starts at index 0.
